// File: rtl/pattern_sync_detector.sv
// rtl/pattern_sync_detector.sv - receive-side sync checker for the 1101000 test pattern; optional polarity auto-detect under PATSYNC_AUTO_POLARITY_EN
module pattern_sync_detector #(
    parameter int CONFIRM_PERIODS = 2,
    parameter int LOSS_THRESH     = 3,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             err_clr,
    output logic             locked,
    output logic [2:0]       phase,
    output logic             bit_err,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_count,
    output logic             inverted
);

    // Oldest bit in the MSB, so PATTERN[6 - phase] is the bit expected at phase.
    localparam logic [6:0] PATTERN = 7'b1101000;

    typedef enum logic [2:0] {
        HUNT   = 3'b001,
        VERIFY = 3'b010,
        LOCKED = 3'b100
    } state_t;

    state_t           state, state_n;
    logic [5:0]       hist, hist_n;
    logic [2:0]       fill, fill_n;
    logic [2:0]       phase_n;
    logic [7:0]       good_cnt, good_n;
    logic [7:0]       bad_cnt, bad_n;
    logic             period_err, period_err_n;
    logic             inverted_n;
    logic             locked_n;
    logic             bit_err_n;
    logic             lock_lost_n;
    logic             err_inc;
    logic [CNT_W-1:0] err_count_n;
    logic             exp_bit;
    logic             mism;
    logic [6:0]       window;
    logic [2:0]       phase_inc;

    assign exp_bit   = PATTERN[3'd6 - phase] ^ inverted;
    assign mism      = (din != exp_bit);
    assign window    = {hist, din};
    assign phase_inc = (phase == 3'd6) ? 3'd0 : phase + 3'd1;

    // State and all outputs are registered; reset forces the hunting idle state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            hist       <= '0;
            fill       <= '0;
            phase      <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            period_err <= 1'b0;
            inverted   <= 1'b0;
            locked     <= 1'b0;
            bit_err    <= 1'b0;
            lock_lost  <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            hist       <= hist_n;
            fill       <= fill_n;
            phase      <= phase_n;
            good_cnt   <= good_n;
            bad_cnt    <= bad_n;
            period_err <= period_err_n;
            inverted   <= inverted_n;
            locked     <= locked_n;
            bit_err    <= bit_err_n;
            lock_lost  <= lock_lost_n;
            err_count  <= err_count_n;
        end
    end

    // Next-state logic: hunt for alignment, confirm clean periods, then track errors while locked.
    always_comb begin
        state_n      = state;
        hist_n       = hist;
        fill_n       = fill;
        phase_n      = phase;
        good_n       = good_cnt;
        bad_n        = bad_cnt;
        period_err_n = period_err;
        inverted_n   = inverted;
        locked_n     = locked;
        bit_err_n    = 1'b0;
        lock_lost_n  = 1'b0;
        err_inc      = 1'b0;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    hist_n = window[5:0];
                    if (fill != 3'd6) begin
                        fill_n = fill + 3'd1;
                    end
                    if (fill == 3'd6 && window == PATTERN) begin
                        state_n    = VERIFY;
                        phase_n    = 3'd0;
                        good_n     = '0;
                        inverted_n = 1'b0;
`ifdef PATSYNC_AUTO_POLARITY_EN
                    end else if (fill == 3'd6 && window == ~PATTERN) begin
                        state_n    = VERIFY;
                        phase_n    = 3'd0;
                        good_n     = '0;
                        inverted_n = 1'b1;
`endif
                    end
                end
                VERIFY: begin
                    phase_n = phase_inc;
                    if (mism) begin
                        // A single miss during confirmation means the alignment was false.
                        bit_err_n  = 1'b1;
                        err_inc    = 1'b1;
                        state_n    = HUNT;
                        fill_n     = '0;
                        phase_n    = 3'd0;
                        inverted_n = 1'b0;
                    end else if (phase == 3'd6) begin
                        good_n = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == 8'(CONFIRM_PERIODS)) begin
                            state_n      = LOCKED;
                            locked_n     = 1'b1;
                            bad_n        = '0;
                            period_err_n = 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    phase_n = phase_inc;
                    if (mism) begin
                        bit_err_n    = 1'b1;
                        err_inc      = 1'b1;
                        period_err_n = 1'b1;
                    end
                    if (phase == 3'd6) begin
                        period_err_n = 1'b0;
                        if (period_err || mism) begin
                            bad_n = bad_cnt + 8'd1;
                            if (bad_cnt + 8'd1 == 8'(LOSS_THRESH)) begin
                                state_n     = HUNT;
                                locked_n    = 1'b0;
                                lock_lost_n = 1'b1;
                                fill_n      = '0;
                                bad_n       = '0;
                                inverted_n  = 1'b0;
                            end
                        end else begin
                            bad_n = '0;
                        end
                    end
                end
                default: begin
                    state_n  = HUNT;
                    fill_n   = '0;
                    phase_n  = 3'd0;
                    locked_n = 1'b0;
                end
            endcase
        end

        // Clear has priority over a coincident increment; the count sticks at all-ones.
        err_count_n = err_count;
        if (err_clr) begin
            err_count_n = '0;
        end else if (err_inc && err_count != {CNT_W{1'b1}}) begin
            err_count_n = err_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/pattern_sync_detector.md
Name: pattern_sync_detector

Overview:
- Receive-side checker for the 7-bit repeating one-hot FSM test pattern 1,1,0,1,0,0,0 (bit order in time, repeats every 7 bits).
- Hunts for pattern alignment, confirms it, tracks phase and counts bit errors.
- Reports lock and loss of lock.
- Sits at the far end of a serial link driven by the pattern generator; internal FSM is one-hot (HUNT, VERIFY, LOCKED).

Parameters:
- CONFIRM_PERIODS, 2, number of consecutive error-free 7-bit periods in VERIFY before LOCKED.
- LOSS_THRESH, 3, number of consecutive errored periods in LOCKED that force HUNT.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- din_valid  input  1  qualifies din; state advances only when high.
- din  input  1  received serial bit.
- err_clr  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- phase  output  3  expected position (0..6) of the next valid bit; 0 = first '1' of the pattern.
- bit_err  output  1  one-cycle pulse: previous valid bit mismatched in VERIFY/LOCKED.
- lock_lost  output  1  one-cycle pulse on LOCKED->HUNT.
- err_count  output  CNT_W  saturating mismatch count.
- inverted  output  1  pattern received with inverted polarity (optional feature; tied 0 without it).

Behaviour:
Reset:
- Asynchronous while reset=0: state=HUNT, shift reg=0, fill=0.
- phase=0, locked=0, bit_err=0, lock_lost=0, err_count=0, inverted=0.

General:
- All outputs registered; an accepted bit's effect is visible the cycle after din_valid=1.
- din_valid=0: state, phase, counters hold; pulses deassert.
- Expected bit per phase: 0:1, 1:1, 2:0, 3:1, 4:0, 5:0, 6:0. Phase wraps 6->0.

HUNT:
- Each valid bit shifts into a 6-bit history; fill saturates at 6.
- Match when fill==6 and {history,din}==7'b1101000 (oldest bit MSB).
- On match: next state VERIFY, phase=0, period-good counter=0.
- Entering HUNT from any state clears fill.

VERIFY:
- Each valid bit is compared with the expected bit for the current phase; phase increments.
- Mismatch: bit_err pulse, err_count++, immediate HUNT, no lock_lost.
- At the end of a clean period (bit at phase 6 correct): good counter++.
- Good counter reaches CONFIRM_PERIODS: go LOCKED, locked=1.

LOCKED:
- Each valid bit is compared; mismatch gives a bit_err pulse and err_count++. Phase always advances.
- At the phase-6 bit: if the period had any error, bad_periods++; else bad_periods=0.
- bad_periods reaches LOSS_THRESH: go HUNT, locked=0, lock_lost pulse in the same cycle locked falls.

err_count:
- Saturates at all-ones.
- err_clr and an increment in the same cycle: clear wins, result is 0.

Optional Feature:
Macro: PATSYNC_AUTO_POLARITY_EN.
- Defined:
  - HUNT also matches 7'b0010111.
  - On that match inverted=1 and all later comparisons use the complemented expected bit.
  - inverted is cleared on entering HUNT and on reset.
- Undefined:
  - Only the true pattern matches.
  - inverted constant 0.

Test Plan:
1. Reset, then a continuous clean pattern from phase 0 (din_valid=1 every cycle) -> match after 7th bit. locked rises after 7+7*2=21 bits with phase=0, err_count=0.
2. Locked, flip one bit at phase 3 -> bit_err pulse one cycle later, err_count=1, locked stays 1. A clean next period resets bad_periods.
3. Locked, one flipped bit in each of 3 consecutive periods -> lock_lost pulse and locked=0 after the 3rd period's phase-6 bit. err_count=3; a clean resume relocks after 21 bits.
4. In VERIFY, a mismatch at the second period's phase 5 -> immediate HUNT, locked never asserts, no lock_lost.
5. din_valid toggled 1/0 every cycle with a clean pattern -> identical lock sequence at half rate. phase holds on invalid cycles.
6. err_count preloaded near saturation (CNT_W=4, 15 errors) plus one more error -> stays 15. err_clr asserted on an error cycle -> 0. Assert reset mid-LOCKED -> all outputs 0 immediately.
